// File: rtl/pmp_lsu_gate.sv
// Data-side load/store gate between the core and the RIB bus.
// Blocks PMP-flagged accesses, watches bus timeouts, records the first fault.
module pmp_lsu_gate #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_data_i,
    output logic [DATA_W-1:0] core_data_o,
    output logic              core_hold_o,
    input  logic              pmp_exception_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    input  logic [DATA_W-1:0] bus_data_i,
    input  logic              bus_ack_i,
    output logic              fault_valid_o,
    output logic [ADDR_W-1:0] fault_addr_o,
    output logic [3:0]        fault_cause_o,
    output logic              fault_timeout_o,
    output logic              fault_ovf_o,
    output logic              fault_irq_o,
    input  logic              fault_clr_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP, FAULT} state_t;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              irq_q, irq_d;
    logic              fv_q, fv_d;
    logic [ADDR_W-1:0] fa_q, fa_d;
    logic [3:0]        fc_q, fc_d;
    logic              ft_q, ft_d;
    logic              ovf_q, ovf_d;

    logic              rec;
    logic [ADDR_W-1:0] rec_addr;
    logic              rec_we;
    logic              rec_to;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        irq_d       = 1'b0;
        fv_d        = fv_q;
        fa_d        = fa_q;
        fc_d        = fc_q;
        ft_d        = ft_q;
        ovf_d       = ovf_q;
        core_hold_o = 1'b0;
        rec         = 1'b0;
        rec_addr    = '0;
        rec_we      = 1'b0;
        rec_to      = 1'b0;

        case (state_q)
            IDLE: begin
                core_hold_o = core_req_i;
                if (core_req_i) begin
                    if (pmp_exception_i) begin
                        state_d  = FAULT;
                        rec      = 1'b1;
                        rec_addr = core_addr_i;
                        rec_we   = core_we_i;
                    end else begin
                        state_d = BUS;
                        req_d   = 1'b1;
                        we_d    = core_we_i;
                        addr_d  = core_addr_i;
                        wdata_d = core_data_i;
                        cnt_d   = '0;
                    end
                end
            end
            BUS: begin
                core_hold_o = 1'b1;
                if (bus_ack_i) begin
                    rdata_d = bus_data_i;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    // Saturating count; reaching TIMEOUT aborts the access
                    cnt_d = (cnt_q == TO_V) ? cnt_q : CW'(cnt_q + 1'b1);
                    if (TIMEOUT != 0 && cnt_d == TO_V) begin
                        req_d    = 1'b0;
                        cnt_d    = '0;
                        state_d  = FAULT;
                        rec      = 1'b1;
                        rec_addr = addr_q;
                        rec_we   = we_q;
                        rec_to   = 1'b1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new fault beats a simultaneous clear
        if (rec) begin
            irq_d   = 1'b1;
            rdata_d = '0;
            if (fault_clr_i || !fv_q) begin
                fv_d  = 1'b1;
                fa_d  = rec_addr;
                fc_d  = rec_we ? 4'd7 : 4'd5;
                ft_d  = rec_to;
                ovf_d = fault_clr_i ? 1'b0 : ovf_q;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (fault_clr_i) begin
            fv_d  = 1'b0;
            ovf_d = 1'b0;
            ft_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
            fv_q    <= 1'b0;
            fa_q    <= '0;
            fc_q    <= '0;
            ft_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
            fv_q    <= fv_d;
            fa_q    <= fa_d;
            fc_q    <= fc_d;
            ft_q    <= ft_d;
            ovf_q   <= ovf_d;
        end
    end

    assign core_data_o     = rdata_q;
    assign bus_req_o       = req_q;
    assign bus_we_o        = we_q;
    assign bus_addr_o      = addr_q;
    assign bus_data_o      = wdata_q;
    assign fault_valid_o   = fv_q;
    assign fault_addr_o    = fa_q;
    assign fault_cause_o   = fc_q;
    assign fault_timeout_o = ft_q;
    assign fault_ovf_o     = ovf_q;
    assign fault_irq_o     = irq_q;

endmodule

// File: tb/tb_pmp_lsu_gate.sv
// Directed bench for pmp_lsu_gate with a short watchdog (TIMEOUT=4).
module tb_pmp_lsu_gate;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [31:0] core_addr_i = '0;
    logic [31:0] core_data_i = '0;
    logic [31:0] core_data_o;
    logic        core_hold_o;
    logic        pmp_exception_i = 1'b0;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i = '0;
    logic        bus_ack_i = 1'b0;
    logic        fault_valid_o;
    logic [31:0] fault_addr_o;
    logic [3:0]  fault_cause_o;
    logic        fault_timeout_o;
    logic        fault_ovf_o;
    logic        fault_irq_o;
    logic        fault_clr_i = 1'b0;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pmp_lsu_gate #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .core_req_i(core_req_i), .core_we_i(core_we_i),
        .core_addr_i(core_addr_i), .core_data_i(core_data_i),
        .core_data_o(core_data_o), .core_hold_o(core_hold_o),
        .pmp_exception_i(pmp_exception_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
        .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i),
        .fault_valid_o(fault_valid_o), .fault_addr_o(fault_addr_o),
        .fault_cause_o(fault_cause_o), .fault_timeout_o(fault_timeout_o),
        .fault_ovf_o(fault_ovf_o), .fault_irq_o(fault_irq_o),
        .fault_clr_i(fault_clr_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_faults();
        fault_clr_i = 1'b1;
        tick();
        fault_clr_i = 1'b0;
    endtask

    task automatic pmp_fault(input logic [31:0] a, input logic we, input logic clr);
        core_req_i = 1'b1; core_we_i = we; core_addr_i = a;
        pmp_exception_i = 1'b1; fault_clr_i = clr;
        tick();
        core_req_i = 1'b0; pmp_exception_i = 1'b0; fault_clr_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #1;
        vecs++;
        if ({bus_req_o, core_hold_o, fault_valid_o, fault_irq_o, fault_ovf_o} !== 5'b0
            || core_data_o !== 32'h0 || bus_addr_o !== 32'h0) begin
            errs++;
            $display("FAIL reset: req=%b hold=%b fv=%b irq=%b ovf=%b data=%h addr=%h, want all 0",
                     bus_req_o, core_hold_o, fault_valid_o, fault_irq_o, fault_ovf_o,
                     core_data_o, bus_addr_o);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load();
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h1000_0004;
        #1;
        vecs++;
        if (core_hold_o !== 1'b1) begin
            errs++; $display("FAIL load_accept_hold: got %b want 1", core_hold_o);
        end
        tick();
        vecs++;
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h1000_0004 || bus_we_o !== 1'b0) begin
            errs++;
            $display("FAIL load_bus1: req=%b addr=%h we=%b want 1/10000004/0",
                     bus_req_o, bus_addr_o, bus_we_o);
        end
        tick();
        vecs++;
        if (bus_req_o !== 1'b1 || core_hold_o !== 1'b1) begin
            errs++; $display("FAIL load_bus2: req=%b hold=%b want 1/1", bus_req_o, core_hold_o);
        end
        bus_ack_i = 1'b1; bus_data_i = 32'hDEAD_BEEF;
        tick();
        bus_ack_i = 1'b0; core_req_i = 1'b0;
        vecs++;
        if (core_data_o !== 32'hDEAD_BEEF || core_hold_o !== 1'b0
            || bus_req_o !== 1'b0 || fault_irq_o !== 1'b0) begin
            errs++;
            $display("FAIL load_resp: data=%h hold=%b req=%b irq=%b want deadbeef/0/0/0",
                     core_data_o, core_hold_o, bus_req_o, fault_irq_o);
        end
        tick();
    endtask

    task automatic test_pmp_store();
        core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = 32'h2000_0000;
        core_data_i = 32'h1234_5678; pmp_exception_i = 1'b1;
        #1;
        vecs++;
        if (core_hold_o !== 1'b1) begin
            errs++; $display("FAIL pmp_accept_hold: got %b want 1", core_hold_o);
        end
        tick();
        core_req_i = 1'b0; pmp_exception_i = 1'b0;
        vecs++;
        if (bus_req_o !== 1'b0 || fault_irq_o !== 1'b1 || fault_valid_o !== 1'b1
            || fault_addr_o !== 32'h2000_0000 || fault_cause_o !== 4'd7
            || fault_timeout_o !== 1'b0 || core_data_o !== 32'h0) begin
            errs++;
            $display("FAIL pmp_store: req=%b irq=%b fv=%b addr=%h cause=%0d to=%b data=%h want 0/1/1/20000000/7/0/0",
                     bus_req_o, fault_irq_o, fault_valid_o, fault_addr_o,
                     fault_cause_o, fault_timeout_o, core_data_o);
        end
        tick();
        vecs++;
        if (fault_irq_o !== 1'b0 || bus_req_o !== 1'b0) begin
            errs++; $display("FAIL pmp_irq_pulse: irq=%b req=%b want 0/0", fault_irq_o, bus_req_o);
        end
        clear_faults();
        vecs++;
        if (fault_valid_o !== 1'b0) begin
            errs++; $display("FAIL pmp_clear: fv=%b want 0", fault_valid_o);
        end
    endtask

    task automatic test_timeout();
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h3000_0000;
        tick();
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (bus_req_o !== 1'b1) begin
                errs++; $display("FAIL to_bus_cycle%0d: req=%b want 1", i + 1, bus_req_o);
            end
            tick();
        end
        core_req_i = 1'b0;
        vecs++;
        if (bus_req_o !== 1'b0 || fault_irq_o !== 1'b1 || fault_valid_o !== 1'b1
            || fault_cause_o !== 4'd5 || fault_timeout_o !== 1'b1
            || fault_addr_o !== 32'h3000_0000) begin
            errs++;
            $display("FAIL to_fault: req=%b irq=%b fv=%b cause=%0d to=%b addr=%h want 0/1/1/5/1/30000000",
                     bus_req_o, fault_irq_o, fault_valid_o, fault_cause_o,
                     fault_timeout_o, fault_addr_o);
        end
        tick();
        clear_faults();
        vecs++;
        if (fault_timeout_o !== 1'b0 || fault_valid_o !== 1'b0) begin
            errs++; $display("FAIL to_clear: to=%b fv=%b want 0/0", fault_timeout_o, fault_valid_o);
        end
        // ack lands in the same cycle the counter would expire
        core_req_i = 1'b1; core_addr_i = 32'h3000_0010;
        tick();
        for (int i = 0; i < 3; i++) tick();
        vecs++;
        if (bus_req_o !== 1'b1) begin
            errs++; $display("FAIL to_ack4_req: req=%b want 1", bus_req_o);
        end
        bus_ack_i = 1'b1; bus_data_i = 32'hCAFE_0004;
        tick();
        bus_ack_i = 1'b0; core_req_i = 1'b0;
        vecs++;
        if (core_data_o !== 32'hCAFE_0004 || fault_irq_o !== 1'b0
            || fault_valid_o !== 1'b0 || bus_req_o !== 1'b0) begin
            errs++;
            $display("FAIL to_ack4_resp: data=%h irq=%b fv=%b req=%b want cafe0004/0/0/0",
                     core_data_o, fault_irq_o, fault_valid_o, bus_req_o);
        end
        tick();
    endtask

    task automatic test_overflow();
        pmp_fault(32'h100, 1'b0, 1'b0);
        pmp_fault(32'h200, 1'b1, 1'b0);
        vecs++;
        if (fault_valid_o !== 1'b1 || fault_addr_o !== 32'h100
            || fault_cause_o !== 4'd5 || fault_ovf_o !== 1'b1) begin
            errs++;
            $display("FAIL ovf_keep_first: fv=%b addr=%h cause=%0d ovf=%b want 1/100/5/1",
                     fault_valid_o, fault_addr_o, fault_cause_o, fault_ovf_o);
        end
        clear_faults();
        vecs++;
        if (fault_ovf_o !== 1'b0 || fault_valid_o !== 1'b0) begin
            errs++; $display("FAIL ovf_clear: ovf=%b fv=%b want 0/0", fault_ovf_o, fault_valid_o);
        end
        pmp_fault(32'h100, 1'b0, 1'b0);
        pmp_fault(32'h200, 1'b1, 1'b1);
        vecs++;
        if (fault_valid_o !== 1'b1 || fault_addr_o !== 32'h200
            || fault_cause_o !== 4'd7 || fault_ovf_o !== 1'b0) begin
            errs++;
            $display("FAIL set_beats_clear: fv=%b addr=%h cause=%0d ovf=%b want 1/200/7/0",
                     fault_valid_o, fault_addr_o, fault_cause_o, fault_ovf_o);
        end
        clear_faults();
    endtask

    task automatic test_async_reset();
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h4000_0000;
        tick();
        vecs++;
        if (bus_req_o !== 1'b1) begin
            errs++; $display("FAIL rst_pre_req: req=%b want 1", bus_req_o);
        end
        #2;
        core_req_i = 1'b0;
        rst = 1'b1;
        #1;
        vecs++;
        if (bus_req_o !== 1'b0 || bus_addr_o !== 32'h0 || core_hold_o !== 1'b0) begin
            errs++;
            $display("FAIL rst_async: req=%b addr=%h hold=%b want 0/0/0",
                     bus_req_o, bus_addr_o, core_hold_o);
        end
        #1;
        rst = 1'b0;
        bus_ack_i = 1'b1; bus_data_i = 32'hBAD0_BAD0;
        tick();
        bus_ack_i = 1'b0;
        tick();
        vecs++;
        if (core_data_o !== 32'h0 || bus_req_o !== 1'b0 || fault_irq_o !== 1'b0) begin
            errs++;
            $display("FAIL rst_late_ack: data=%h req=%b irq=%b want 0/0/0",
                     core_data_o, bus_req_o, fault_irq_o);
        end
        core_req_i = 1'b1; core_addr_i = 32'h4000_0008;
        tick();
        bus_ack_i = 1'b1; bus_data_i = 32'h0BAD_F00D;
        tick();
        bus_ack_i = 1'b0; core_req_i = 1'b0;
        vecs++;
        if (core_data_o !== 32'h0BAD_F00D || core_hold_o !== 1'b0) begin
            errs++;
            $display("FAIL rst_next_load: data=%h hold=%b want 0badf00d/0", core_data_o, core_hold_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h5000_0000;
        tick();
        bus_ack_i = 1'b1; bus_data_i = 32'h1111_1111;
        tick();
        bus_ack_i = 1'b0;
        core_addr_i = 32'h5000_0004;
        vecs++;
        if (core_data_o !== 32'h1111_1111 || bus_req_o !== 1'b0 || core_hold_o !== 1'b0) begin
            errs++;
            $display("FAIL b2b_resp1: data=%h req=%b hold=%b want 11111111/0/0",
                     core_data_o, bus_req_o, core_hold_o);
        end
        tick();
        vecs++;
        if (bus_req_o !== 1'b0 || core_hold_o !== 1'b1) begin
            errs++;
            $display("FAIL b2b_idle: req=%b hold=%b want 0/1", bus_req_o, core_hold_o);
        end
        tick();
        vecs++;
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h5000_0004) begin
            errs++;
            $display("FAIL b2b_bus2: req=%b addr=%h want 1/50000004", bus_req_o, bus_addr_o);
        end
        bus_ack_i = 1'b1; bus_data_i = 32'h2222_2222;
        tick();
        bus_ack_i = 1'b0; core_req_i = 1'b0;
        vecs++;
        if (core_data_o !== 32'h2222_2222 || bus_req_o !== 1'b0) begin
            errs++;
            $display("FAIL b2b_resp2: data=%h req=%b want 22222222/0", core_data_o, bus_req_o);
        end
        tick();
        vecs++;
        if (bus_req_o !== 1'b0 || core_data_o !== 32'h2222_2222) begin
            errs++;
            $display("FAIL b2b_hold_data: req=%b data=%h want 0/22222222", bus_req_o, core_data_o);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_pmp_store();
        test_timeout();
        test_overflow();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
